// File: rtl/cgra_cfg_arbiter_pkg.sv
// Shared definitions for the per-PRR CGRA configuration-port arbiter.
package cgra_cfg_arbiter_pkg;

  localparam int CGRA_CFG_ADDR_WIDTH = 32;
  localparam int CGRA_CFG_DATA_WIDTH = 32;
  localparam int NUM_PRR             = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of an index into n masters; at least one bit so a port always exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_cfg_arbiter_rr_picker.sv
// Round-robin first-set search: lowest offset from rr_ptr_i with a valid request wins.
module cfg_rr_picker
  import cgra_cfg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset back to rr_ptr so the closest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = IDX_W'((int'(rr_ptr_i) + i) % NUM_REQ);
      if (req_valid_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/cgra_cfg_arbiter.sv
// Arbitrates NUM_REQ configuration masters onto one PRR's CGRA cfg port.
// Round-robin grants with burst locking, registered issue, and read
// responses routed back to the issuing master by a captured ID.
module cgra_cfg_arbiter #(
  parameter int NUM_REQ             = 2,
  parameter int CGRA_CFG_ADDR_WIDTH = cgra_cfg_arbiter_pkg::CGRA_CFG_ADDR_WIDTH,
  parameter int CGRA_CFG_DATA_WIDTH = cgra_cfg_arbiter_pkg::CGRA_CFG_DATA_WIDTH,
  parameter int GRANT_MAX           = 16,
  parameter int IDLE_TIMEOUT        = 8
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NUM_REQ-1:0]                                  req_valid,
  output logic [NUM_REQ-1:0]                                  req_ready,
  input  logic [NUM_REQ-1:0]                                  req_wr,
  input  logic [NUM_REQ-1:0]                                  req_last,
  input  logic [NUM_REQ-1:0][CGRA_CFG_ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_REQ-1:0][CGRA_CFG_DATA_WIDTH-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]                                  rsp_valid,
  output logic [CGRA_CFG_DATA_WIDTH-1:0]                      rsp_rdata,
  output logic                                                cfg_wr_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0]                      cfg_wr_addr,
  output logic [CGRA_CFG_DATA_WIDTH-1:0]                      cfg_wr_data,
  output logic                                                cfg_rd_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0]                      cfg_rd_addr,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0]                      cfg_rd_data,
  output logic                                                busy
);

  import cgra_cfg_arbiter_pkg::*;

  localparam int OW = idx_w(NUM_REQ);
  localparam int BW = $clog2(GRANT_MAX + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [OW-1:0]          pick_idx;
  logic                   pick_found;
  logic [OW-1:0]          owner_inc;
  logic                   accept;
  logic                   acc_wr;
  logic                   acc_last;

  logic                           wr_en_q, rd_en_q;
  logic [CGRA_CFG_ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [CGRA_CFG_DATA_WIDTH-1:0] wr_data_q;
  logic [OW-1:0]                  rd_id_q;
  logic                           rsp_vld_q;
  logic [OW-1:0]                  rsp_id_q;
  logic [CGRA_CFG_DATA_WIDTH-1:0] rsp_data_q;

  cfg_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_picker (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .idx_o       (pick_idx),
    .found_o     (pick_found)
  );

  // Beat handshake decode; ready depends only on registered state and owner.
  always_comb begin
    req_ready = '0;
    if (state_q == GRANT) req_ready[owner_q] = 1'b1;
    accept    = (state_q == GRANT) && req_valid[owner_q];
    acc_wr    = req_wr[owner_q];
    acc_last  = req_last[owner_q];
    owner_inc = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
  end

  // Next-state logic: pick an owner in IDLE, hold the grant until last, beat cap or idle timeout.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (acc_last || (beat_cnt_q == BW'(GRANT_MAX - 1))) begin
            state_d  = IDLE;
            rr_ptr_d = owner_inc;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            idle_cnt_d = '0;
          end
        end else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Issue stage: an accepted beat drives the CGRA port for one cycle, zeros otherwise;
  // the response stage captures read data with the issuing master's ID one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_id_q    <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      wr_en_q    <= accept && acc_wr;
      wr_addr_q  <= (accept && acc_wr) ? req_addr[owner_q] : '0;
      wr_data_q  <= (accept && acc_wr) ? req_wdata[owner_q] : '0;
      rd_en_q    <= accept && !acc_wr;
      rd_addr_q  <= (accept && !acc_wr) ? req_addr[owner_q] : '0;
      rd_id_q    <= owner_q;
      rsp_vld_q  <= rd_en_q;
      rsp_id_q   <= rd_id_q;
      rsp_data_q <= rd_en_q ? cfg_rd_data : '0;
    end
  end

  // Response fan-out and status.
  always_comb begin
    rsp_valid = '0;
    if (rsp_vld_q) rsp_valid[rsp_id_q] = 1'b1;
    busy = (state_q != IDLE) || rd_en_q || rsp_vld_q;
  end

  assign rsp_rdata   = rsp_data_q;
  assign cfg_wr_en   = wr_en_q;
  assign cfg_wr_addr = wr_addr_q;
  assign cfg_wr_data = wr_data_q;
  assign cfg_rd_en   = rd_en_q;
  assign cfg_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_cgra_cfg_arbiter.sv
// Bench for cgra_cfg_arbiter: per-cycle vector tables with expected ready,
// plus a scoreboard of expected CGRA issues and read responses.
module tb_cgra_cfg_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid, req_ready, req_wr, req_last;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              cfg_wr_en, cfg_rd_en, busy;
  logic [31:0]       cfg_wr_addr, cfg_wr_data, cfg_rd_addr, cfg_rd_data;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [1:0]  valid, wr, last;
    logic        rst;
    logic [31:0] a0, d0, a1, d1;
    logic [1:0]  er;
  } vec_t;

  typedef struct { int due; logic wr; logic [31:0] addr; logic [31:0] data; } iss_t;
  typedef struct { int due; logic [1:0] vld; logic [31:0] data; } rsp_t;

  vec_t vq[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t mon_ie;
  rsp_t mon_re;

  cgra_cfg_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_last    (req_last),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_rd_en   (cfg_rd_en),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rd_data (cfg_rd_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CGRA register file model: read data depends on the address.
  function automatic logic [31:0] cgra_rd(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  assign cfg_rd_data = cgra_rd(cfg_rd_addr);

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [1:0] er, input logic rst = 1'b0);
    vec_t t;
    t.valid = v; t.wr = w; t.last = l; t.rst = rst;
    t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.er = er;
    return t;
  endfunction

  task automatic push_beat(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
    iss_t ie;
    rsp_t re;
    ie.due = cyc + 1; ie.wr = wr; ie.addr = a; ie.data = wr ? d : 32'h0;
    iss_q.push_back(ie);
    if (!wr) begin
      re.due = cyc + 2; re.vld = 2'b00; re.vld[m] = 1'b1; re.data = cgra_rd(a);
      rsp_q.push_back(re);
    end
  endtask

  task automatic drop_pending();
    for (int k = iss_q.size() - 1; k >= 0; k--) if (iss_q[k].due > cyc) iss_q.delete(k);
    for (int k = rsp_q.size() - 1; k >= 0; k--) if (rsp_q[k].due > cyc) rsp_q.delete(k);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      reset        = vq[i].rst;
      req_valid    = vq[i].valid;
      req_wr       = vq[i].wr;
      req_last     = vq[i].last;
      req_addr[0]  = vq[i].a0;
      req_wdata[0] = vq[i].d0;
      req_addr[1]  = vq[i].a1;
      req_wdata[1] = vq[i].d1;
      if (vq[i].rst) drop_pending();
      else begin
        if (vq[i].valid[0] && vq[i].er[0]) push_beat(0, vq[i].wr[0], vq[i].a0, vq[i].d0);
        if (vq[i].valid[1] && vq[i].er[1]) push_beat(1, vq[i].wr[1], vq[i].a1, vq[i].d1);
      end
      @(negedge clk);
      chk("req_ready", 160'(req_ready), 160'(vq[i].er));
    end
    vq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 160'(req_ready), 160'(0));
    chk({tag, "_cfg"}, 160'({cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr}), 160'(0));
    chk({tag, "_rsp"}, 160'({rsp_valid, rsp_rdata}), 160'(0));
    chk({tag, "_busy"}, 160'(busy), 160'(0));
  endtask

  // Scoreboard monitor: compares CGRA issues and read responses against the expected queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg_wr_en || cfg_rd_en || (iss_q.size() > 0 && iss_q[0].due <= cyc)) begin
        chk("wr_rd_exclusive", 160'(cfg_wr_en & cfg_rd_en), 160'(0));
        if (iss_q.size() == 0) chk("issue_unexpected", 160'({cfg_wr_en, cfg_rd_en}), 160'(0));
        else begin
          mon_ie = iss_q.pop_front();
          chk("issue", {30'h0, cyc, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr},
              mon_ie.wr ? {30'h0, mon_ie.due, 1'b1, mon_ie.addr, mon_ie.data, 1'b0, 32'h0}
                        : {30'h0, mon_ie.due, 1'b0, 32'h0, 32'h0, 1'b1, mon_ie.addr});
        end
      end else begin
        chk("issue_idle_zero", 160'({cfg_wr_addr, cfg_wr_data, cfg_rd_addr}), 160'(0));
      end
      if (rsp_valid != 2'b00 || (rsp_q.size() > 0 && rsp_q[0].due <= cyc)) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 160'({rsp_valid, rsp_rdata}), 160'(0));
        else begin
          mon_re = rsp_q.pop_front();
          chk("rsp", {94'h0, cyc, rsp_valid, rsp_rdata}, {94'h0, mon_re.due, mon_re.vld, mon_re.data});
        end
      end else begin
        chk("rsp_idle_zero", 160'(rsp_rdata), 160'(0));
      end
    end
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_wr = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single write from master 0.
    vq.push_back(mk(2'b01, 2'b01, 2'b01, 32'h1000_0003, 32'hDEAD_BEEF, 0, 0, 2'b00));
    vq.push_back(mk(2'b01, 2'b01, 2'b01, 32'h1000_0003, 32'hDEAD_BEEF, 0, 0, 2'b01));
    vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    run_vecs();

    // Three pipelined reads from master 1.
    vq.push_back(mk(2'b10, 2'b00, 2'b00, 0, 0, 32'h2000_0010, 0, 2'b00));
    vq.push_back(mk(2'b10, 2'b00, 2'b00, 0, 0, 32'h2000_0010, 0, 2'b10));
    vq.push_back(mk(2'b10, 2'b00, 2'b00, 0, 0, 32'h2000_0020, 0, 2'b10));
    vq.push_back(mk(2'b10, 2'b00, 2'b10, 0, 0, 32'h2000_0030, 0, 2'b10));
    for (int i = 0; i < 3; i++) vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    run_vecs();

    // Contention: single-beat bursts, master 0 writes, master 1 reads.
    for (int g = 0; g < 12; g++) begin
      vq.push_back(mk(2'b11, 2'b01, 2'b11, 32'h100 + g, 32'h1000 + g, 32'h200 + g, 0, 2'b00));
      vq.push_back(mk(2'b11, 2'b01, 2'b11, 32'h100 + g, 32'h1000 + g, 32'h200 + g, 0,
                      (g % 2 == 0) ? 2'b01 : 2'b10));
    end
    for (int i = 0; i < 3; i++) vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    run_vecs();

    // Beat cap: master 0 streams 20 beats, master 1 waits with a single write.
    vq.push_back(mk(2'b11, 2'b11, 2'b10, 32'h301, 32'h3001, 32'h400, 32'hBBBB, 2'b00));
    for (int k = 1; k <= 16; k++)
      vq.push_back(mk(2'b11, 2'b11, 2'b10, 32'h300 + k, 32'h3000 + k, 32'h400, 32'hBBBB, 2'b01));
    vq.push_back(mk(2'b11, 2'b11, 2'b10, 32'h311, 32'h3011, 32'h400, 32'hBBBB, 2'b00));
    vq.push_back(mk(2'b11, 2'b11, 2'b10, 32'h311, 32'h3011, 32'h400, 32'hBBBB, 2'b10));
    vq.push_back(mk(2'b01, 2'b11, 2'b00, 32'h311, 32'h3011, 0, 0, 2'b00));
    for (int k = 17; k <= 20; k++)
      vq.push_back(mk(2'b01, 2'b11, (k == 20) ? 2'b01 : 2'b00, 32'h300 + k, 32'h3000 + k, 0, 0, 2'b01));
    vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    run_vecs();

    // Idle timeout after one read; last during IDLE must be ignored.
    vq.push_back(mk(2'b01, 2'b00, 2'b01, 32'h0000_0777, 0, 0, 0, 2'b00));
    vq.push_back(mk(2'b01, 2'b00, 2'b00, 32'h0000_0777, 0, 0, 0, 2'b01));
    for (int i = 0; i < 8; i++) vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01));
    vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    run_vecs();

    // Reset during beat 3 of a burst; beat 2 is a read whose response must be dropped.
    vq.push_back(mk(2'b01, 2'b01, 2'b00, 32'h500, 32'hA0, 0, 0, 2'b00));
    vq.push_back(mk(2'b01, 2'b01, 2'b00, 32'h501, 32'hA1, 0, 0, 2'b01));
    vq.push_back(mk(2'b01, 2'b00, 2'b00, 32'h502, 32'h0, 0, 0, 2'b01));
    vq.push_back(mk(2'b01, 2'b01, 2'b00, 32'h503, 32'hA3, 0, 0, 2'b01, 1'b1));
    run_vecs();
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b11; req_wr = 2'b11; req_last = 2'b11;
    req_addr[0] = 32'h600; req_wdata[0] = 32'hC0; req_addr[1] = 32'h700; req_wdata[1] = 32'hD0;
    @(negedge clk);
    chk_all_zero("post_reset");
    vq.push_back(mk(2'b11, 2'b11, 2'b11, 32'h600, 32'hC0, 32'h700, 32'hD0, 2'b01));
    vq.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
    run_vecs();

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("issue_queue_drained", 160'(iss_q.size()), 160'(0));
    chk("rsp_queue_drained", 160'(rsp_q.size()), 160'(0));
    chk("final_busy", 160'(busy), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
